mem_burst_arbiter: RTL
======================

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters (name, default, meaning), each SHALL exist:
- ADDR_W, 32, byte-address width on all three ports
- DATA_W, 32, data width on all three ports
- STARVE_MAX, 4, consecutive VGA grants tolerated while camera is waiting
REQ-003 Ports (name, direction, width, meaning) SHALL be exactly:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cam_address  in  ADDR_W  camera write-burst start address
- cam_write  in  1  camera write request / beat valid
- cam_writedata  in  DATA_W  camera write beat
- cam_burstcount  in  6  camera burst length, beats
- cam_waitrequest  out  1  camera stall
- vga_address  in  ADDR_W  VGA read-burst start address
- vga_read  in  1  VGA read request
- vga_burstcount  in  6  VGA burst length, beats
- vga_urgent  in  1  VGA FIFO below half-full
- vga_waitrequest  out  1  VGA stall
- vga_readdata  out  DATA_W  read beat to VGA
- vga_readdatavalid  out  1  read beat valid to VGA
- avm_address  out  ADDR_W  shared memory master address
- avm_read  out  1  master read
- avm_write  out  1  master write
- avm_writedata  out  DATA_W  master write beat
- avm_burstcount  out  6  master burst length
- avm_waitrequest  in  1  memory stall
- avm_readdata  in  DATA_W  memory read beat
- avm_readdatavalid  in  1  memory read beat valid
- arb_state  out  2  FSM state for debug: 0 IDLE, 1 CAM_WR, 2 VGA_CMD, 3 VGA_RD

Function
REQ-004 FSM SHALL have states IDLE, CAM_WR, VGA_CMD, VGA_RD; arbitration decisions are made only in IDLE, so grants change only at burst boundaries.
REQ-005 IDLE grant priority, highest first:
- cam_write with starve count = STARVE_MAX
- vga_read with vga_urgent
- otherwise, with both requesting, the requester not granted last
- otherwise, the sole requester
REQ-006 The grant SHALL take effect on the next cycle; in IDLE both waitrequests = 1 and avm_read = avm_write = 0.
REQ-007 At grant, burstcount SHALL be latched into a beat counter; burstcount 0 is treated as 1.
REQ-008 CAM_WR SHALL combinationally forward cam_address, cam_write, cam_writedata and the latched burstcount to avm_*, with cam_waitrequest = avm_waitrequest.
REQ-009 Each cam_write & !avm_waitrequest SHALL decrement the beat counter; on the last beat the FSM returns to IDLE next cycle; cam_write low mid-burst SHALL hold CAM_WR (no abort).
REQ-010 VGA_CMD SHALL forward vga_address, vga_read and the latched burstcount, with vga_waitrequest = avm_waitrequest; on acceptance (avm_read & !avm_waitrequest) it goes to VGA_RD.
REQ-011 VGA_RD SHALL assert vga_waitrequest = 1 and issue no command; each avm_readdatavalid decrements the counter, and the last beat returns the FSM to IDLE next cycle.
REQ-012 vga_readdata SHALL always equal avm_readdata; vga_readdatavalid = avm_readdatavalid only in VGA_RD, otherwise 0 (stray beats dropped).
REQ-013 The non-granted requester SHALL see waitrequest = 1.
REQ-014 Starve count SHALL increment, saturating at STARVE_MAX, on each VGA grant while cam_write = 1, and clear on a camera grant.
REQ-015 The last-granted flag SHALL update on every grant.

Reset
REQ-016 When reset is sampled high, the block SHALL enter IDLE and clear beat counter, starve count and last-granted (treated as VGA) on the same edge, including mid-burst; outputs then take IDLE values: both waitrequests = 1, avm_read = avm_write = 0, vga_readdatavalid = 0, arb_state = 0.

Verification
REQ-017 The bench SHALL cover:
- cam_write only, burstcount 8, avm_waitrequest 0 -> arb_state 1 for 8 cycles, 8 avm_write beats, then IDLE.
- Both request, vga_urgent 0, last = VGA -> camera granted, then VGA on the next IDLE.
- vga_urgent 1 held with cam_write 1, STARVE_MAX 4 -> 4 VGA bursts, then camera granted.
- VGA burst 16, memory returns 16 valid beats with gaps -> exactly 16 vga_readdatavalid, vga_waitrequest 1 throughout VGA_RD.
- Reset asserted at beat 3 of 8 in CAM_WR -> next cycle arb_state 0, avm_write 0, cam_waitrequest 1.
- cam_burstcount 0 -> exactly one beat forwarded.

Source files
------------

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: two-client burst arbiter sharing one memory master between a camera
// write stream and a VGA read stream, switching grants only at burst boundaries.
module mem_burst_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cam_address,
    input  logic              cam_write,
    input  logic [DATA_W-1:0] cam_writedata,
    input  logic [5:0]        cam_burstcount,
    output logic              cam_waitrequest,
    input  logic [ADDR_W-1:0] vga_address,
    input  logic              vga_read,
    input  logic [5:0]        vga_burstcount,
    input  logic              vga_urgent,
    output logic              vga_waitrequest,
    output logic [DATA_W-1:0] vga_readdata,
    output logic              vga_readdatavalid,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [5:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [1:0]        arb_state
);
    typedef enum logic [1:0] {IDLE, CAM_WR, VGA_CMD, VGA_RD} state_t;
    localparam int SW = $clog2(STARVE_MAX + 1);
    state_t        state_q;
    logic [5:0]    bc_q;
    logic [5:0]    beats_q;
    logic [SW-1:0] starve_q;
    logic          last_cam_q;
    logic          starved;
    logic          gnt_cam;
    logic          gnt_vga;
    logic [5:0]    cam_bc;
    logic [5:0]    vga_bc;
    assign starved = starve_q == SW'(STARVE_MAX);
    // Camera wins when starved, or when VGA is absent / not urgent and VGA was served last.
    assign gnt_cam = cam_write && (starved || !(vga_read && (vga_urgent || last_cam_q)));
    assign gnt_vga = vga_read && !gnt_cam;
    assign cam_bc  = (cam_burstcount == 6'd0) ? 6'd1 : cam_burstcount;
    assign vga_bc  = (vga_burstcount == 6'd0) ? 6'd1 : vga_burstcount;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bc_q       <= '0;
            beats_q    <= '0;
            starve_q   <= '0;
            last_cam_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_cam) begin
                        state_q    <= CAM_WR;
                        bc_q       <= cam_bc;
                        beats_q    <= cam_bc;
                        starve_q   <= '0;
                        last_cam_q <= 1'b1;
                    end else if (gnt_vga) begin
                        state_q    <= VGA_CMD;
                        bc_q       <= vga_bc;
                        beats_q    <= vga_bc;
                        last_cam_q <= 1'b0;
                        if (cam_write && !starved) starve_q <= starve_q + SW'(1);
                    end
                end
                CAM_WR: begin
                    if (cam_write && !avm_waitrequest) begin
                        beats_q <= beats_q - 6'd1;
                        if (beats_q == 6'd1) state_q <= IDLE;
                    end
                end
                VGA_CMD: begin
                    if (vga_read && !avm_waitrequest) state_q <= VGA_RD;
                end
                VGA_RD: begin
                    if (avm_readdatavalid) begin
                        beats_q <= beats_q - 6'd1;
                        if (beats_q == 6'd1) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign avm_address       = (state_q == VGA_CMD) ? vga_address : cam_address;
    assign avm_writedata     = cam_writedata;
    assign avm_burstcount    = bc_q;
    assign avm_write         = (state_q == CAM_WR) && cam_write;
    assign avm_read          = (state_q == VGA_CMD) && vga_read;
    assign cam_waitrequest   = (state_q == CAM_WR) ? avm_waitrequest : 1'b1;
    assign vga_waitrequest   = (state_q == VGA_CMD) ? avm_waitrequest : 1'b1;
    assign vga_readdata      = avm_readdata;
    assign vga_readdatavalid = (state_q == VGA_RD) && avm_readdatavalid;
    assign arb_state         = state_q;
endmodule
